// File: rtl/cell_mem_pkg.sv
// Shared definitions for the cell-memory arbiter: requester tags and grid defaults.
package cell_mem_pkg;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_VGA  = 2'd1,
    REQ_UART = 2'd2,
    REQ_LIFE = 2'd3
  } req_id_t;

  localparam int GRID_W         = 80;
  localparam int GRID_H         = 60;
  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/cell_mem_rr_pick.sv
// Two-way round-robin selector; pick=0 selects req[0], pick=1 selects req[1].
module cell_mem_rr_pick (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       pick
);

  logic ptr;

  // Sole requester always wins; the pointer only breaks ties.
  always_comb begin
    pick = req[1];
    if (req == 2'b11) pick = ptr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ptr <= 1'b0;
    else if (advance) ptr <= ~pick;
  end

endmodule

// File: rtl/cell_mem_arbiter.sv
// Single-port cell-memory arbiter: VGA priority, starvation pre-emption, UART/life round-robin.
// Optional statistics counters built when CELL_MEM_ARB_STATS_EN is defined.
module cell_mem_arbiter
  import cell_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vga_req,
  input  logic                  uart_req,
  input  logic                  life_req,
  input  logic                  vga_we,
  input  logic                  uart_we,
  input  logic                  life_we,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  input  logic [ADDR_WIDTH-1:0] uart_addr,
  input  logic [ADDR_WIDTH-1:0] life_addr,
  input  logic [DATA_WIDTH-1:0] uart_wdata,
  input  logic [DATA_WIDTH-1:0] life_wdata,
  output logic                  vga_gnt,
  output logic                  uart_gnt,
  output logic                  life_gnt,
  output logic                  vga_rvalid,
  output logic                  uart_rvalid,
  output logic                  life_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           stat_preempt,
  output logic [15:0]           stat_conflict
);

  localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [1:0]          low_req;
  logic                low_any;
  logic                low_gnt;
  logic                pick;
  logic                preempt;
  logic [STARVE_W-1:0] starve_cnt;
  req_id_t             gnt_id;
  req_id_t             rd_tag;

  assign low_req = {life_req, uart_req};
  assign low_any = |low_req;

  cell_mem_rr_pick u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (low_req),
    .advance (low_gnt),
    .pick    (pick)
  );

  assign preempt = (STARVE_LIMIT != 0) && low_any &&
                   (starve_cnt == STARVE_W'(STARVE_LIMIT));

  always_comb begin
    gnt_id = REQ_NONE;
    if (!reset) begin
      if (preempt || (!vga_req && low_any)) gnt_id = pick ? REQ_LIFE : REQ_UART;
      else if (vga_req)                     gnt_id = REQ_VGA;
    end
  end

  assign vga_gnt  = (gnt_id == REQ_VGA);
  assign uart_gnt = (gnt_id == REQ_UART);
  assign life_gnt = (gnt_id == REQ_LIFE);
  assign low_gnt  = uart_gnt | life_gnt;
  assign mem_en   = (gnt_id != REQ_NONE);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (gnt_id)
      REQ_VGA:  begin mem_we = vga_we;  mem_addr = vga_addr;                          end
      REQ_UART: begin mem_we = uart_we; mem_addr = uart_addr; mem_wdata = uart_wdata; end
      REQ_LIFE: begin mem_we = life_we; mem_addr = life_addr; mem_wdata = life_wdata; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                             starve_cnt <= '0;
    else if (low_gnt || !low_any)                          starve_cnt <= '0;
    else if (vga_gnt && starve_cnt < STARVE_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                rd_tag <= REQ_NONE;
    else if (mem_en && !mem_we) rd_tag <= gnt_id;
    else                      rd_tag <= REQ_NONE;
  end

  assign vga_rvalid  = (rd_tag == REQ_VGA);
  assign uart_rvalid = (rd_tag == REQ_UART);
  assign life_rvalid = (rd_tag == REQ_LIFE);
  assign rdata       = mem_rdata;

`ifdef CELL_MEM_ARB_STATS_EN
  logic multi_req;
  assign multi_req = (vga_req & uart_req) | (vga_req & life_req) | (uart_req & life_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_preempt  <= '0;
      stat_conflict <= '0;
    end else begin
      if (preempt && low_gnt && stat_preempt != '1)  stat_preempt  <= stat_preempt + 1'b1;
      if (multi_req && stat_conflict != '1)          stat_conflict <= stat_conflict + 1'b1;
    end
  end
`else
  assign stat_preempt  = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_cell_mem_arbiter.sv
// Directed self-checking bench for cell_mem_arbiter with a behavioural 1-cycle memory.
module tb_cell_mem_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vga_req, uart_req, life_req;
  logic          vga_we, uart_we, life_we;
  logic [AW-1:0] vga_addr, uart_addr, life_addr;
  logic [DW-1:0] uart_wdata, life_wdata;
  logic          vga_gnt, uart_gnt, life_gnt;
  logic          vga_rvalid, uart_rvalid, life_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [15:0]   stat_preempt, stat_conflict;

  logic          z_vga_gnt, z_uart_gnt, z_life_gnt;
  logic          z_vga_rvalid, z_uart_rvalid, z_life_rvalid;
  logic [DW-1:0] z_rdata;
  logic          z_mem_en, z_mem_we;
  logic [AW-1:0] z_mem_addr;
  logic [DW-1:0] z_mem_wdata;
  logic [15:0]   z_stat_preempt, z_stat_conflict;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cell_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(15)) dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .uart_req(uart_req), .life_req(life_req),
    .vga_we(vga_we), .uart_we(uart_we), .life_we(life_we),
    .vga_addr(vga_addr), .uart_addr(uart_addr), .life_addr(life_addr),
    .uart_wdata(uart_wdata), .life_wdata(life_wdata),
    .vga_gnt(vga_gnt), .uart_gnt(uart_gnt), .life_gnt(life_gnt),
    .vga_rvalid(vga_rvalid), .uart_rvalid(uart_rvalid), .life_rvalid(life_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_preempt(stat_preempt), .stat_conflict(stat_conflict)
  );

  // Second instance with the starvation guard disabled, sharing the request inputs.
  cell_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(0)) dut0 (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .uart_req(uart_req), .life_req(life_req),
    .vga_we(vga_we), .uart_we(uart_we), .life_we(life_we),
    .vga_addr(vga_addr), .uart_addr(uart_addr), .life_addr(life_addr),
    .uart_wdata(uart_wdata), .life_wdata(life_wdata),
    .vga_gnt(z_vga_gnt), .uart_gnt(z_uart_gnt), .life_gnt(z_life_gnt),
    .vga_rvalid(z_vga_rvalid), .uart_rvalid(z_uart_rvalid), .life_rvalid(z_life_rvalid),
    .rdata(z_rdata), .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr),
    .mem_wdata(z_mem_wdata), .mem_rdata(mem_rdata),
    .stat_preempt(z_stat_preempt), .stat_conflict(z_stat_conflict)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] mem_q = '0;
  assign mem_rdata = mem_q;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_q <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  logic life_seen, vga_missed, cnt_moved;
  logic [15:0] exp_preempt;

  initial begin
    mem[13'h010] <= 8'hA1;
    mem[13'h020] <= 8'hB2;
    mem[13'h030] <= 8'hC3;
    reset = 1'b1;
    vga_req = 0; uart_req = 0; life_req = 0;
    vga_we = 0; uart_we = 0; life_we = 0;
    vga_addr = '0; uart_addr = '0; life_addr = '0;
    uart_wdata = '0; life_wdata = '0;
`ifdef CELL_MEM_ARB_STATS_EN
    exp_preempt = 16'd1;
`else
    exp_preempt = 16'd0;
`endif

    // Reset state, with requests asserted to confirm grants are suppressed.
    #2;
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_rvalid", 32'({vga_rvalid, uart_rvalid, life_rvalid}), 0);
    chk("rst_stats", 32'({stat_preempt, stat_conflict}), 0);
    vga_req = 1; uart_req = 1; life_req = 1;
    #1;
    chk("rst_gnt_forced", 32'({vga_gnt, uart_gnt, life_gnt}), 0);
    vga_req = 0; uart_req = 0; life_req = 0;
    next();
    reset = 1'b0;
    next();

    // Concurrent reads: VGA first, then UART, then life.
    vga_req = 1;  vga_addr = 13'h010;
    uart_req = 1; uart_addr = 13'h020;
    life_req = 1; life_addr = 13'h030;
    #2;
    chk("t1_gnt_vga", 32'({vga_gnt, uart_gnt, life_gnt}), 32'b100);
    chk("t1_addr_vga", 32'(mem_addr), 32'h010);
    next(); vga_req = 0; #2;
    chk("t1_vga_rvalid", 32'(vga_rvalid), 1);
    chk("t1_rdata_a1", 32'(rdata), 32'hA1);
    chk("t1_gnt_uart", 32'({vga_gnt, uart_gnt, life_gnt}), 32'b010);
    chk("t1_addr_uart", 32'(mem_addr), 32'h020);
    next(); uart_req = 0; #2;
    chk("t1_uart_rvalid", 32'({vga_rvalid, uart_rvalid, life_rvalid}), 32'b010);
    chk("t1_rdata_b2", 32'(rdata), 32'hB2);
    chk("t1_gnt_life", 32'({vga_gnt, uart_gnt, life_gnt}), 32'b001);
    next(); life_req = 0; #2;
    chk("t1_life_rvalid", 32'({vga_rvalid, uart_rvalid, life_rvalid}), 32'b001);
    chk("t1_rdata_c3", 32'(rdata), 32'hC3);
    chk("t1_idle", 32'(mem_en), 0);

    // UART write and life read held together: strict alternation U,L,U,L,U,L.
    next();
    uart_req = 1; uart_we = 1; uart_addr = 13'h200; uart_wdata = 8'h11;
    life_req = 1; life_we = 0; life_addr = 13'h300;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk($sformatf("t2_uart_gnt_%0d", i), 32'(uart_gnt), 32'((i % 2) == 0));
      chk($sformatf("t2_life_gnt_%0d", i), 32'(life_gnt), 32'((i % 2) == 1));
      chk($sformatf("t2_we_%0d", i), 32'(mem_we), 32'((i % 2) == 0));
      chk($sformatf("t2_addr_%0d", i), 32'(mem_addr), ((i % 2) == 0) ? 32'h200 : 32'h300);
      next();
    end
    uart_req = 0; uart_we = 0; life_req = 0;

    // Starvation guard: VGA for 15 cycles, UART pre-empts on cycle 16.
    vga_req = 1;  vga_addr = 13'h040;
    uart_req = 1; uart_addr = 13'h050;
    for (int c = 1; c <= 16; c++) begin
      #2;
      chk($sformatf("t3_uart_gnt_c%0d", c), 32'(uart_gnt), 32'(c == 16));
      chk($sformatf("t3_vga_gnt_c%0d", c), 32'(vga_gnt), 32'(c != 16));
      next();
    end
    uart_req = 0;
    #2;
    chk("t3_vga_resumes", 32'(vga_gnt), 1);
    chk("t3_starve_cleared", 32'(dut.starve_cnt), 0);
    chk("t3_stat_preempt", 32'(stat_preempt), 32'(exp_preempt));
    next(); vga_req = 0;

    // Guard disabled: life never granted while VGA is held.
    vga_req = 1; life_req = 1; life_we = 0; life_addr = 13'h060;
    life_seen = 0; vga_missed = 0; cnt_moved = 0;
    for (int c = 0; c < 100; c++) begin
      #2;
      life_seen  = life_seen | z_life_gnt;
      vga_missed = vga_missed | ~z_vga_gnt;
      cnt_moved  = cnt_moved | (dut0.starve_cnt != '0);
      next();
    end
    chk("t4_life_never", 32'(life_seen), 0);
    chk("t4_vga_always", 32'(vga_missed), 0);
    chk("t4_starve_zero", 32'(cnt_moved), 0);
    chk("t4_stat_none", 32'(z_stat_preempt), 0);
    vga_req = 0; life_req = 0;
    next();

    // Life write then UART read of the same cell.
    life_req = 1; life_we = 1; life_addr = 13'h100; life_wdata = 8'h5A;
    #2;
    chk("t5_life_gnt", 32'(life_gnt), 1);
    chk("t5_we_high", 32'(mem_we), 1);
    chk("t5_addr", 32'(mem_addr), 32'h100);
    chk("t5_wdata", 32'(mem_wdata), 32'h5A);
    next(); life_req = 0; life_we = 0;
    uart_req = 1; uart_we = 0; uart_addr = 13'h100;
    #2;
    chk("t5_uart_gnt", 32'(uart_gnt), 1);
    chk("t5_we_low", 32'(mem_we), 0);
    chk("t5_no_life_rvalid_w", 32'(life_rvalid), 0);
    next(); uart_req = 0; #2;
    chk("t5_uart_rvalid", 32'({vga_rvalid, uart_rvalid, life_rvalid}), 32'b010);
    chk("t5_rdata_5a", 32'(rdata), 32'h5A);

    // Reset right after a granted UART read discards the pending rvalid.
    next();
    uart_req = 1; uart_addr = 13'h020;
    #2;
    chk("t6_uart_gnt", 32'(uart_gnt), 1);
    next();
    reset = 1; vga_req = 1; life_req = 1;
    #2;
    chk("t6_rvalid_lost", 32'({vga_rvalid, uart_rvalid, life_rvalid}), 0);
    chk("t6_gnt_reset", 32'({vga_gnt, uart_gnt, life_gnt}), 0);
    chk("t6_mem_en_reset", 32'(mem_en), 0);
    chk("t6_stats_reset", 32'({stat_preempt, stat_conflict}), 0);
    next(); #2;
    chk("t6_rvalid_still0", 32'({vga_rvalid, uart_rvalid, life_rvalid}), 0);
    next();
    reset = 0; vga_req = 0;
    #2;
    chk("t6_first_uart", 32'({vga_gnt, uart_gnt, life_gnt}), 32'b010);
    chk("t6_no_rvalid", 32'(uart_rvalid), 0);
    next();
    uart_req = 0; life_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
